// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce,
// a DATA/CTRL register pair and a level interrupt.
// Optional feature macro: KEYPAD_IRQ_EN. When it is defined, CTRL[0] (ie) is a
// writable enable and irq = DATA[31] & ie. When it is undefined, irq is tied
// low and CTRL[0] reads 0.
//
// Debounce FSM (evaluated only at frame completion):
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for any key press in a frame
//   PRESS_DB   | same candidate seen for cnt_q consecutive frames
//   HELD       | key accepted and latched, waiting for release
//   RELEASE_DB | empty frames counted in cnt_q before returning to IDLE
module keypad_scanner #(
  parameter int SCAN_DIV     = 200,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic [3:0]  key_row,
  input  logic [3:0]  key_col,
  output logic        irq
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_RELEASE_DB
  } state_t;

  logic [1:0]    row_q;
  logic [DW-1:0] div_q;
  logic [15:0]   snap_q;
  logic [15:0]   snap_d;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cand_q;
  logic          valid_q;
  logic [3:0]    code_q;
  logic          ovr_q;
  logic          ie;

  logic          row_last;
  logic          frame_done;
  logic          cand_hit;
  logic [3:0]    cand_code;
  logic          latch_now;
  logic          rd_clr;
  logic          ctrl_wr;

  assign key_row    = ~(4'b0001 << row_q);
  assign row_last   = (div_q == DIV_LAST);
  assign frame_done = row_last && (row_q == 2'd3);
  assign rd_clr     = rd && !addr[2];
  assign ctrl_wr    = (|byteen) && addr[2] && byteen[0];
  assign cnt_inc    = cnt_q + CW'(1);

  // Snapshot as it will look after this cycle's sample, so the frame's
  // candidate already includes the row 3 columns on the completing edge.
  always_comb begin
    snap_d = snap_q;
    if (row_last) begin
      snap_d[{row_q, 2'b00} +: 4] = ~key_col;
    end
  end

  // Lowest set snapshot bit wins when several keys are down.
  always_comb begin
    cand_hit  = 1'b0;
    cand_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap_d[i]) begin
        cand_hit  = 1'b1;
        cand_code = 4'(i);
      end
    end
  end

  assign latch_now = frame_done && (state_q == S_PRESS_DB) && cand_hit &&
                     (cand_code == cand_q) && (cnt_inc == CNT_DONE);

  // Row rotation, dwell counter and column sampling; never stalled by the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= 2'd0;
      div_q  <= '0;
      snap_q <= 16'h0000;
    end else if (row_last) begin
      div_q  <= '0;
      row_q  <= row_q + 2'd1;
      snap_q <= snap_d;
    end else begin
      div_q  <= div_q + DW'(1);
    end
  end

  // Debounce FSM stepping once per completed frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
    end else if (frame_done) begin
      case (state_q)
        S_IDLE: begin
          if (cand_hit) begin
            state_q <= S_PRESS_DB;
            cnt_q   <= CW'(1);
            cand_q  <= cand_code;
          end
        end
        S_PRESS_DB: begin
          if (!cand_hit) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cand_code != cand_q) begin
            cnt_q   <= CW'(1);
            cand_q  <= cand_code;
          end else if (cnt_inc == CNT_DONE) begin
            state_q <= S_HELD;
            cnt_q   <= cnt_inc;
          end else begin
            cnt_q   <= cnt_inc;
          end
        end
        S_HELD: begin
          if (!cand_hit) begin
            state_q <= S_RELEASE_DB;
            cnt_q   <= CW'(1);
          end
        end
        S_RELEASE_DB: begin
          if (cand_hit) begin
            state_q <= S_HELD;
          end else if (cnt_inc == CNT_DONE) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_inc;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // DATA valid/code and sticky overrun; a latch beats a same-cycle read-clear
  // and an overrun set beats a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      code_q  <= 4'd0;
      ovr_q   <= 1'b0;
    end else begin
      if (latch_now) begin
        valid_q <= 1'b1;
        code_q  <= cand_code;
      end else if (rd_clr) begin
        valid_q <= 1'b0;
      end
      if (latch_now && valid_q && !rd_clr) begin
        ovr_q <= 1'b1;
      end else if (ctrl_wr && wdata[1]) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_IRQ_EN
  logic ie_q;

  // Interrupt enable bit, software writable through CTRL byte 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q <= 1'b0;
    end else if (ctrl_wr) begin
      ie_q <= wdata[0];
    end
  end

  assign ie  = ie_q;
  assign irq = valid_q & ie_q;

  logic unused_ok;
  assign unused_ok = ^{addr[31:3], addr[1:0], wdata[31:2]};
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{addr[31:3], addr[1:0], wdata[31:2], wdata[0]};
`endif

  assign rdata = addr[2] ? {30'b0, ovr_q, ie} : {valid_q, 27'b0, code_q};

endmodule
